// File: rtl/slice_lane_collector_if.sv
// Slice-in / lane-out handshake bundle for the slice lane collector.
// master = producer/consumer side, slave = collector side.
interface slice_lane_collector_if #(
   parameter int NUM_CELLS  = 25,
   parameter int NUM_SLICES = 64,
   parameter int LEN_LANE   = 5
);
   logic [NUM_CELLS-1:0]  slice_in;
   logic                  slice_valid;
   logic                  slice_ready;
   logic [NUM_SLICES-1:0] lane_out;
   logic [LEN_LANE-1:0]   lane_idx;
   logic                  lane_valid;
   logic                  lane_ready;
   logic                  busy;
   logic                  done;

   modport master (
      output slice_in, slice_valid, lane_ready,
      input  slice_ready, lane_out, lane_idx,
      input  lane_valid, busy, done
   );

   modport slave (
      input  slice_in, slice_valid, lane_ready,
      output slice_ready, lane_out, lane_idx,
      output lane_valid, busy, done
   );
endinterface

// File: rtl/slice_lane_collector.sv
// Buffers 64 slices of 25 cells, then returns the
// state transposed as 25 lane-serial 64-bit words.
module slice_lane_collector #(
   parameter int NUM_CELLS  = 25,
   parameter int NUM_SLICES = 64,
   parameter int LEN_SLICE  = 6,
   parameter int LEN_LANE   = 5
) (
   input  logic clk,
   input  logic rst,
   slice_lane_collector_if.slave bus
);

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

   localparam logic [LEN_SLICE-1:0] SLICE_LAST =
      LEN_SLICE'(NUM_SLICES - 1);
   localparam logic [LEN_LANE-1:0]  LANE_LAST  =
      LEN_LANE'(NUM_CELLS - 1);

   state_t                state_q, state_d;
   logic [LEN_SLICE-1:0]  slice_cnt_q, slice_cnt_d;
   logic [LEN_LANE-1:0]   lane_idx_q, lane_idx_d;
   logic                  done_q, done_d;
   logic [NUM_CELLS-1:0]  buf_q [NUM_SLICES];
   logic                  slice_acc;
   logic [NUM_SLICES-1:0] lane_mux;

   // Next-state: count slices in, then step lanes out under handshake.
   always_comb begin
      state_d     = state_q;
      slice_cnt_d = slice_cnt_q;
      lane_idx_d  = lane_idx_q;
      done_d      = 1'b0;
      slice_acc   = 1'b0;
      unique case (state_q)
         COLLECT: begin
            slice_acc = bus.slice_valid;
            if (bus.slice_valid) begin
               if (slice_cnt_q == SLICE_LAST) begin
                  slice_cnt_d = '0;
                  state_d     = EMIT;
               end else begin
                  slice_cnt_d = slice_cnt_q + LEN_SLICE'(1);
               end
            end
         end
         EMIT: begin
            if (bus.lane_ready) begin
               if (lane_idx_q == LANE_LAST) begin
                  lane_idx_d = '0;
                  done_d     = 1'b1;
                  state_d    = COLLECT;
               end else begin
                  lane_idx_d = lane_idx_q + LEN_LANE'(1);
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Control state; a reset drops any partial state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= COLLECT;
         slice_cnt_q <= '0;
         lane_idx_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         slice_cnt_q <= slice_cnt_d;
         lane_idx_q  <= lane_idx_d;
         done_q      <= done_d;
      end
   end

   // Slice buffer, written at the slice counter; never cleared.
   always_ff @(posedge clk) begin
      if (slice_acc) begin
         buf_q[slice_cnt_q] <= bus.slice_in;
      end
   end

   // Transpose read: bit z of the lane is cell lane_idx of slice z.
   always_comb begin
      lane_mux = '0;
      for (int z = 0; z < NUM_SLICES; z++) begin
         lane_mux[z] = buf_q[z][lane_idx_q];
      end
   end

   assign bus.slice_ready = (state_q == COLLECT);
   assign bus.lane_valid  = (state_q == EMIT);
   assign bus.lane_out    = (state_q == EMIT) ? lane_mux : '0;
   assign bus.lane_idx    = lane_idx_q;
   assign bus.busy        = (state_q == EMIT) || (slice_cnt_q != '0);
   assign bus.done        = done_q;

endmodule

// File: tb/tb_slice_lane_collector.sv
// Randomized bench for slice_lane_collector against a
// queue-based transpose model.
module tb_slice_lane_collector;

   logic clk = 1'b0;
   logic rst = 1'b1;

   slice_lane_collector_if bus ();

   slice_lane_collector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [24:0] slices [64];
   int          nsl = 0;
   logic [63:0] lanes_q [$];
   logic        exp_done = 1'b0;
   int          cyc = 0;
   int          done_cyc [$];

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            nsl = 0;
            lanes_q.delete();
            exp_done = 1'b0;
         end else begin
            logic emit;
            logic nxt_done;
            cyc++;
            emit = (lanes_q.size() != 0);
            nxt_done = 1'b0;
            chk("slice_ready", 64'(bus.slice_ready), 64'(!emit));
            chk("lane_valid", 64'(bus.lane_valid), 64'(emit));
            chk("busy", 64'(bus.busy), 64'(emit || nsl != 0));
            chk("done", 64'(bus.done), 64'(exp_done));
            if (bus.done) done_cyc.push_back(cyc);
            if (emit) begin
               chk("lane_idx", 64'(bus.lane_idx),
                   64'(25 - lanes_q.size()));
               chk("lane_out", bus.lane_out, lanes_q[0]);
               if (bus.lane_ready) begin
                  void'(lanes_q.pop_front());
                  if (lanes_q.size() == 0) nxt_done = 1'b1;
               end
            end else begin
               chk("lane_out_gated", bus.lane_out, 64'd0);
               if (bus.slice_valid) begin
                  slices[nsl] = bus.slice_in;
                  nsl++;
                  if (nsl == 64) begin
                     for (int k = 0; k < 25; k++) begin
                        logic [63:0] l;
                        for (int z = 0; z < 64; z++)
                           l[z] = slices[z][k];
                        lanes_q.push_back(l);
                     end
                     nsl = 0;
                  end
               end
            end
            exp_done = nxt_done;
         end
      end
   end

   // ---------------- lane_ready driver ----------------
   int lr_mode = 0;
   int hold = 0;

   initial begin
      bus.lane_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (lr_mode)
            0: bus.lane_ready = 1'b1;
            1: bus.lane_ready = ($urandom % 4) != 0;
            default: begin
               if (bus.lane_valid && bus.lane_idx == 5'd7
                   && hold < 10) begin
                  bus.lane_ready = 1'b0;
                  hold++;
               end else begin
                  bus.lane_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------- slice driver ----------------
   int gcyc = 0;

   function automatic logic [24:0] gen(input int kind,
                                       input int z);
      logic [24:0] one;
      one = 25'd1;
      case (kind)
         0: return one << (z % 25);
         1: return '1;
         default: return 25'($urandom);
      endcase
   endfunction

   task automatic send_slices(input int kind, input int gap,
                              input int n);
      for (int z = 0; z < n; z++) begin
         logic acc;
         int   t;
         acc = 1'b0;
         t = 0;
         while (!acc && t < 1000) begin
            bus.slice_in    = gen(kind, z);
            bus.slice_valid = gap ? (gcyc % 3 != 2) : 1'b1;
            @(negedge clk);
            acc = bus.slice_valid && bus.slice_ready;
            @(posedge clk);
            #1;
            gcyc++;
            t++;
         end
         if (!acc) chk("slice_timeout", 64'd0, 64'd1);
      end
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < 2000 && !seen; t++) begin
         @(negedge clk);
         seen = bus.done;
      end
      if (!seen) chk("done_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.slice_in    = '0;
      bus.slice_valid = 1'b0;
      #2;
      chk("rst_slice_ready", 64'(bus.slice_ready), 64'd1);
      chk("rst_lane_valid", 64'(bus.lane_valid), 64'd0);
      chk("rst_lane_out", bus.lane_out, 64'd0);
      chk("rst_lane_idx", 64'(bus.lane_idx), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // one-hot diagonal pattern, no gaps
      lr_mode = 0;
      send_slices(0, 0, 64);
      bus.slice_valid = 1'b0;
      wait_done();

      // same pattern, valid dropped every third cycle
      send_slices(0, 1, 64);
      bus.slice_valid = 1'b0;
      wait_done();

      // stall on lane 7 for 10 cycles
      lr_mode = 2;
      hold = 0;
      send_slices(2, 0, 64);
      bus.slice_valid = 1'b0;
      wait_done();

      // junk slices offered during emit
      lr_mode = 0;
      send_slices(2, 0, 64);
      for (int i = 0; i < 20; i++) begin
         bus.slice_valid = 1'b1;
         bus.slice_in    = 25'($urandom);
         @(posedge clk);
         #1;
      end
      bus.slice_valid = 1'b0;
      wait_done();

      // reset after a partial state
      send_slices(2, 0, 40);
      bus.slice_valid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_slice_ready", 64'(bus.slice_ready), 64'd1);
      chk("arst_done", 64'(bus.done), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      lr_mode = 1;
      send_slices(1, 0, 64);
      bus.slice_valid = 1'b0;
      wait_done();

      // random data, random gaps and backpressure
      for (int s = 0; s < 3; s++) begin
         send_slices(2, s % 2, 64);
         bus.slice_valid = 1'b0;
         wait_done();
      end

      // back-to-back states, lane_ready held high
      lr_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      done_cyc.delete();
      send_slices(2, 0, 64);
      send_slices(2, 0, 64);
      send_slices(2, 0, 64);
      bus.slice_valid = 1'b0;
      wait_done();
      chk("b2b_count", 64'(done_cyc.size()), 64'd3);
      if (done_cyc.size() == 3) begin
         chk("b2b_period1", 64'(done_cyc[1] - done_cyc[0]), 64'd89);
         chk("b2b_period2", 64'(done_cyc[2] - done_cyc[1]), 64'd89);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               nchk, nerr);
      $finish;
   end

endmodule
